// File: rtl/ysyx_210457_axi_rw_pkg.sv
// Shared encodings for the single-beat AXI read/write bridge: FSM states,
// AXI response and burst codes, and requester tags.
package ysyx_210457_axi_rw_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [3:0] ID_MEM = 4'b0001;
  localparam logic [3:0] ID_IF  = 4'b0011;

endpackage

// File: rtl/ysyx_210457_axi_rw.sv
// Single-outstanding AXI4 master bridge: turns one arbitrated load/store
// request into a single-beat AXI read or write and returns the response.
module ysyx_210457_axi_rw
  import ysyx_210457_axi_rw_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_ID_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [63:0]           req_addr,
  input  logic [63:0]           req_wdata,
  input  logic [1:0]            req_size,
  input  logic [3:0]            req_id,
  output logic                  stall,
  output logic [3:0]            rsp_id,
  output logic [63:0]           rsp_rdata,
  output logic                  rsp_err,

  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_ADDR_W-1:0] awaddr,
  output logic [AXI_ID_W-1:0]   awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,

  output logic                  wvalid,
  input  logic                  wready,
  output logic [63:0]           wdata,
  output logic [7:0]            wstrb,
  output logic                  wlast,

  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  input  logic [AXI_ID_W-1:0]   bid,

  output logic                  arvalid,
  input  logic                  arready,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,

  input  logic                  rvalid,
  output logic                  rready,
  input  logic [63:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [AXI_ID_W-1:0]   rid
);

  // Bytes past the end of the 8-byte beat fall off the top of both results.
  function automatic logic [63:0] align_wdata(input logic [63:0] d, input logic [2:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [7:0] byte_strobe(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] mask;
    case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << off;
  endfunction

  state_e                state, next;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [63:0]           wdata_q;
  logic [1:0]            size_q;
  logic [3:0]            id_q;
  logic                  aw_done, w_done;

  logic unused_inputs;
  assign unused_inputs = ^{req_addr[63:AXI_ADDR_W], rid, bid};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      id_q      <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= next;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[AXI_ADDR_W-1:0];
            wdata_q <= req_wdata;
            size_q  <= req_size;
            id_q    <= req_id;
          end
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        S_RD_DATA: begin
          if (rvalid && rlast) begin
            rsp_rdata <= rdata >> {addr_q[2:0], 3'b000};
            rsp_err   <= (rresp != RESP_OKAY);
            rsp_id    <= id_q;
          end
        end
        S_WR_REQ: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
        end
        S_WR_RESP: begin
          if (bvalid) begin
            rsp_rdata <= '0;
            rsp_err   <= (bresp != RESP_OKAY);
            rsp_id    <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next    = state;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (state)
      S_IDLE:    if (req_valid) next = req_write ? S_WR_REQ : S_RD_ADDR;
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) next = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) next = S_DONE;
      end
      S_WR_REQ: begin
        // Each channel drops its valid once its own handshake is recorded.
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) next = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) next = S_DONE;
      end
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  assign stall   = (req_valid && state == S_IDLE) || (state != S_IDLE && state != S_DONE);

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awid    = AXI_ID_W'(id_q);
  assign arid    = AXI_ID_W'(id_q);
  assign awlen   = '0;
  assign arlen   = '0;
  assign awsize  = {1'b0, size_q};
  assign arsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;
  assign arburst = BURST_INCR;
  assign wlast   = 1'b1;
  assign wdata   = align_wdata(wdata_q, addr_q[2:0]);
  assign wstrb   = byte_strobe(size_q, addr_q[2:0]);

endmodule
